// File: rtl/echo_peak_detector_if.sv
// Purpose: groups the sample stream, control and result signals of the echo
//   peak detector into one bundle.
// Signals:
//   iStart      arm/restart a measurement (one-cycle pulse)
//   iValid      filter sample strobe
//   iData       signed filter sample
//   iThreshold  unsigned echo detection threshold
//   oBusy       measurement in progress
//   oDone       one-cycle pulse when the result outputs update
//   oPeakValue  unsigned magnitude of the window maximum
//   oPeakIndex  sample index of that maximum
//   oFound      oPeakValue exceeded the threshold latched at start
// Modports: master drives the stream and reads results; slave is the detector.
interface echo_peak_detector_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 10
);
  logic              iStart;
  logic              iValid;
  logic [DATA_W-1:0] iData;
  logic [DATA_W-1:0] iThreshold;
  logic              oBusy;
  logic              oDone;
  logic [DATA_W-1:0] oPeakValue;
  logic [IDX_W-1:0]  oPeakIndex;
  logic              oFound;

  modport master (
    output iStart, iValid, iData, iThreshold,
    input  oBusy, oDone, oPeakValue, oPeakIndex, oFound
  );

  modport slave (
    input  iStart, iValid, iData, iThreshold,
    output oBusy, oDone, oPeakValue, oPeakIndex, oFound
  );
endinterface

// File: rtl/echo_peak_detector.sv
// Purpose: finds the largest-magnitude sample of the FIR output over a window
//   of WINDOW accepted samples and reports its magnitude and index (the echo
//   time-of-flight). One measurement per iStart, followed by a oDone strobe.
// Ports:
//   CLK    system clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    echo_peak_detector_if.slave (stream in, results out)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no measurement running; samples ignored, results held
// CAPTURE | accepting samples, tracking running max and its index
module echo_peak_detector #(
  parameter int DATA_W = 32,
  parameter int WINDOW = 1024,
  parameter int IDX_W  = 10
) (
  input logic              CLK,
  input logic              reset,
  echo_peak_detector_if.slave bus
);

  typedef enum logic {IDLE, CAPTURE} state_t;

  state_t            state, stateNext;
  logic [IDX_W-1:0]  count, countNext;
  logic [DATA_W-1:0] runMax, runMaxNext;
  logic [IDX_W-1:0]  runIdx, runIdxNext;
  logic [DATA_W-1:0] thr, thrNext;
  logic [DATA_W-1:0] peakValue, peakValueNext;
  logic [IDX_W-1:0]  peakIndex, peakIndexNext;
  logic              found, foundNext;
  logic              done, doneNext;

  logic [DATA_W-1:0] mag;
  logic              isNewMax;
  logic [DATA_W-1:0] maxSel;
  logic [IDX_W-1:0]  idxSel;

  // Two's-complement negate in DATA_W bits: the most negative input maps to
  // 2^(DATA_W-1), which is exact when read as unsigned.
  assign mag      = bus.iData[DATA_W-1] ? (~bus.iData + 1'b1) : bus.iData;
  assign isNewMax = mag > runMax;
  assign maxSel   = isNewMax ? mag   : runMax;
  assign idxSel   = isNewMax ? count : runIdx;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= '0;
      runMax    <= '0;
      runIdx    <= '0;
      thr       <= '0;
      peakValue <= '0;
      peakIndex <= '0;
      found     <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= stateNext;
      count     <= countNext;
      runMax    <= runMaxNext;
      runIdx    <= runIdxNext;
      thr       <= thrNext;
      peakValue <= peakValueNext;
      peakIndex <= peakIndexNext;
      found     <= foundNext;
      done      <= doneNext;
    end
  end

  always_comb begin
    stateNext     = state;
    countNext     = count;
    runMaxNext    = runMax;
    runIdxNext    = runIdx;
    thrNext       = thr;
    peakValueNext = peakValue;
    peakIndexNext = peakIndex;
    foundNext     = found;
    doneNext      = 1'b0;

    // A start has priority over everything, including a final sample on the
    // same edge: the window restarts and the sample is discarded.
    if (bus.iStart) begin
      stateNext  = CAPTURE;
      countNext  = '0;
      runMaxNext = '0;
      runIdxNext = '0;
      thrNext    = bus.iThreshold;
    end else if (state == CAPTURE && bus.iValid) begin
      runMaxNext = maxSel;
      runIdxNext = idxSel;
      if (count == IDX_W'(WINDOW - 1)) begin
        peakValueNext = maxSel;
        peakIndexNext = idxSel;
        foundNext     = maxSel > thr;
        doneNext      = 1'b1;
        stateNext     = IDLE;
        countNext     = '0;
      end else begin
        countNext = count + 1'b1;
      end
    end
  end

  assign bus.oBusy      = (state == CAPTURE);
  assign bus.oDone      = done;
  assign bus.oPeakValue = peakValue;
  assign bus.oPeakIndex = peakIndex;
  assign bus.oFound     = found;

endmodule

// File: tb/tb_echo_peak_detector.sv
// Purpose: self-checking bench for echo_peak_detector with WINDOW=8.
//   Stimulus pushes hand-computed results into a queue; a monitor pops and
//   compares whenever oDone is seen.
module tb_echo_peak_detector;
  localparam int DATA_W = 32;
  localparam int WINDOW = 8;
  localparam int IDX_W  = 3;

  typedef struct packed {
    logic [DATA_W-1:0] value;
    logic [IDX_W-1:0]  index;
    logic              found;
  } result_t;

  logic CLK = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  result_t expQ[$];
  logic [DATA_W-1:0] vec [WINDOW];

  echo_peak_detector_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

  echo_peak_detector #(.DATA_W(DATA_W), .WINDOW(WINDOW), .IDX_W(IDX_W)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic expectResult(input logic [DATA_W-1:0] v, input logic [IDX_W-1:0] i, input logic f);
    result_t r;
    r.value = v;
    r.index = i;
    r.found = f;
    expQ.push_back(r);
  endtask

  // Monitor: every oDone must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (reset && bus.oDone) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpectedDone actual=1 required=0");
      end else begin
        result_t r;
        r = expQ.pop_front();
        chk("peakValue", 64'(bus.oPeakValue), 64'(r.value));
        chk("peakIndex", 64'(bus.oPeakIndex), 64'(r.index));
        chk("found", 64'(bus.oFound), 64'(r.found));
        chk("busyAtDone", 64'(bus.oBusy), 64'd0);
      end
    end
  end

  task automatic chkOutputsZero(input string name);
    chk(name, {bus.oBusy, bus.oDone, bus.oFound, 58'(bus.oPeakIndex)}, 64'd0);
    chk(name, 64'(bus.oPeakValue), 64'd0);
  endtask

  // One full window from vec[]; threshold thrMid is driven after the start
  // edge and must not affect the result.
  task automatic runWindow(input bit gaps, input logic [DATA_W-1:0] thr,
                           input logic [DATA_W-1:0] thrMid);
    bus.iThreshold = thr;
    bus.iStart = 1'b1;
    bus.iValid = 1'b0;
    step();
    bus.iStart = 1'b0;
    bus.iThreshold = thrMid;
    chk("busyAfterStart", 64'(bus.oBusy), 64'd1);
    for (int i = 0; i < WINDOW; i++) begin
      if (gaps) begin
        int n;
        n = int'($urandom_range(0, 3));
        for (int g = 0; g < n; g++) begin
          bus.iValid = 1'b0;
          bus.iData = $urandom;
          step();
        end
      end
      bus.iValid = 1'b1;
      bus.iData = vec[i];
      step();
      if (i < WINDOW - 1) chk("noEarlyDone", 64'(bus.oDone), 64'd0);
    end
    bus.iValid = 1'b0;
    chk("doneLatency", 64'(bus.oDone), 64'd1);
    chk("busyFalls", 64'(bus.oBusy), 64'd0);
    step();
    chk("donePulseWidth", 64'(bus.oDone), 64'd0);
  endtask

  initial begin
    bus.iStart = 1'b0;
    bus.iValid = 1'b0;
    bus.iData = '0;
    bus.iThreshold = '0;

    // Reset held with random inputs
    for (int c = 0; c < 5; c++) begin
      bus.iStart = 1'($urandom);
      bus.iValid = 1'($urandom);
      bus.iData = $urandom;
      bus.iThreshold = $urandom;
      step();
      chkOutputsZero("resetHeld");
    end
    bus.iStart = 1'b0;
    bus.iValid = 1'b0;
    reset = 1'b1;
    step();
    step();
    chkOutputsZero("afterRelease");

    // Back-to-back stream
    vec = '{32'd1, 32'hFFFF_FFFB, 32'd3, 32'd5, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd4};
    expectResult(32'd5, 3'd1, 1'b1);
    runWindow(1'b0, 32'd4, 32'd4);

    // Same stream with gaps
    expectResult(32'd5, 3'd1, 1'b1);
    runWindow(1'b1, 32'd4, 32'd4);

    // Most negative value
    vec = '{32'd1, 32'd2, 32'd3, 32'hFFFF_FFFC, 32'd5, 32'd6, 32'h8000_0000, 32'd7};
    expectResult(32'h8000_0000, 3'd6, 1'b1);
    runWindow(1'b0, 32'd100, 32'd100);

    // Strict compare; mid-window threshold change ignored
    vec = '{32'd1, 32'hFFFF_FFFB, 32'd3, 32'd5, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd4};
    expectResult(32'd5, 3'd1, 1'b0);
    runWindow(1'b0, 32'd5, 32'd0);

    // Max on the final sample
    vec = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'hFFFF_FFEC};
    expectResult(32'd20, 3'd7, 1'b1);
    runWindow(1'b1, 32'd19, 32'd19);

    // Start+valid in IDLE drops the sample; then all-zero window
    bus.iThreshold = 32'd0;
    bus.iStart = 1'b1;
    bus.iValid = 1'b1;
    bus.iData = 32'd999;
    step();
    bus.iStart = 1'b0;
    for (int i = 0; i < WINDOW; i++) begin
      bus.iValid = 1'b1;
      bus.iData = 32'd0;
      step();
    end
    bus.iValid = 1'b0;
    expectResult(32'd0, 3'd0, 1'b0);
    step();
    chk("zeroWindowDone", 64'(expQ.size()), 64'd0);

    // Restart after 3 samples; sample on the restart edge discarded
    bus.iThreshold = 32'd200;
    bus.iStart = 1'b1;
    step();
    bus.iStart = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.iValid = 1'b1;
      bus.iData = 32'd50 + 32'(i);
      step();
    end
    bus.iThreshold = 32'd3;
    bus.iStart = 1'b1;
    bus.iValid = 1'b1;
    bus.iData = 32'd1000;
    step();
    bus.iStart = 1'b0;
    vec = '{32'd0, 32'd0, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    expectResult(32'd9, 3'd2, 1'b1);
    for (int i = 0; i < WINDOW; i++) begin
      bus.iValid = 1'b1;
      bus.iData = vec[i];
      step();
    end
    bus.iValid = 1'b0;
    chk("restartDone", 64'(bus.oDone), 64'd1);
    step();

    // Restart on the final-sample edge wins
    bus.iThreshold = 32'd0;
    bus.iStart = 1'b1;
    step();
    bus.iStart = 1'b0;
    for (int i = 0; i < WINDOW - 1; i++) begin
      bus.iValid = 1'b1;
      bus.iData = 32'd100;
      step();
    end
    bus.iStart = 1'b1;
    bus.iData = 32'd500;
    step();
    bus.iStart = 1'b0;
    chk("restartBeatsFinal", 64'(bus.oDone), 64'd0);
    chk("busyAfterRestart", 64'(bus.oBusy), 64'd1);
    expectResult(32'd8, 3'd7, 1'b1);
    for (int i = 0; i < WINDOW; i++) begin
      bus.iValid = 1'b1;
      bus.iData = 32'(i + 1);
      step();
    end
    bus.iValid = 1'b0;
    step();

    // Reset after 4 samples aborts with no done
    bus.iStart = 1'b1;
    step();
    bus.iStart = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.iValid = 1'b1;
      bus.iData = 32'd77;
      step();
    end
    bus.iValid = 1'b0;
    reset = 1'b0;
    #2;
    chkOutputsZero("midReset");
    step();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.iValid = 1'b1;
      bus.iData = 32'd5;
      step();
    end
    bus.iValid = 1'b0;
    step();
    chkOutputsZero("afterAbort");

    step();
    chk("scoreboardEmpty", 64'(expQ.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
